// File: rtl/spi_pkg.sv
// Shared constants, frame field positions and FSM state type for the SPI
// control-path frame receiver.
package spi_pkg;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 16;
    localparam int MAX_ADDR   = 4;

    // Bit positions inside a received 16-bit frame (MSB arrives first).
    localparam int SHIFT_W  = 16;
    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for one asynchronous pad input, with single-cycle
// rise/fall pulses derived from one extra registered copy of the synced value.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI frame receiver: synchronises SCLK/COPI/nCS, deserialises 16-bit frames
// and turns valid register writes into a one-cycle address/data strobe.
module spi_frame_rx
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = spi_pkg::FRAME_BITS,
    parameter int MAX_ADDR    = spi_pkg::MAX_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk_i,
    input  logic              copi_i,
    input  logic              ncs_i,
    output logic              wr_valid_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              frame_err_o,
    output logic [3:0]        err_cnt_o,
    output logic              busy_o
);

    // Counter holds 0..FRAME_BITS+1; the top value flags an over-long frame.
    localparam int                CNT_W    = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic copi_s, copi_rise, copi_fall;
    logic ncs_s, ncs_rise, ncs_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk_i), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d(copi_i), .q(copi_s), .rise(copi_rise), .fall(copi_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d(ncs_i), .q(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_s, sclk_fall, copi_rise, copi_fall, ncs_s};

    state_e             state_q, state_d;
    logic [SHIFT_W-1:0] shift_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               start_en, shift_en, check_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // An nCS fall seen during CHECK goes straight to SHIFT so back-to-back
    // frames are not lost.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ncs_fall) state_d = SHIFT;
            SHIFT:   if (ncs_rise) state_d = CHECK;
            CHECK:   state_d = ncs_fall ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // nCS rising wins over a coincident SCLK edge; SCLK outside SHIFT is ignored.
    always_comb begin
        busy_o   = (state_q != IDLE);
        start_en = ncs_fall && (state_q != SHIFT);
        shift_en = (state_q == SHIFT) && sclk_rise && !ncs_rise;
        check_en = (state_q == CHECK);
    end

    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_data;
    logic              len_ok, write_ok, read_ok, reject;

    assign frame_addr = shift_q[ADDR_MSB:ADDR_LSB];
    assign frame_data = shift_q[DATA_MSB:DATA_LSB];
    assign len_ok     = (cnt_q == CNT_FULL);
    assign write_ok   = len_ok && shift_q[RW_BIT] && (frame_addr <= ADDR_W'(MAX_ADDR));
    assign read_ok    = len_ok && !shift_q[RW_BIT];
    assign reject     = !(write_ok || read_ok);

    // wr_valid_o is a one-cycle strobe with no ready: the register file must
    // take wr_addr_o/wr_data_o in the cycle the strobe is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            wr_valid_o  <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
            frame_err_o <= 1'b0;
            err_cnt_o   <= '0;
        end else begin
            wr_valid_o  <= check_en && write_ok;
            frame_err_o <= check_en && reject;
            if (start_en) begin
                shift_q <= '0;
                cnt_q   <= '0;
            end else if (shift_en) begin
                shift_q <= {shift_q[SHIFT_W-2:0], copi_s};
                if (cnt_q != CNT_SAT) cnt_q <= cnt_q + CNT_W'(1);
            end
            if (check_en && write_ok) begin
                wr_addr_o <= frame_addr;
                wr_data_o <= frame_data;
            end
            if (check_en && reject && (err_cnt_o != 4'hF)) begin
                err_cnt_o <= err_cnt_o + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: table of frames with hand-computed results,
// plus back-to-back, mid-frame reset and error-counter saturation sequences.
module tb_spi_frame_rx;
    import spi_pkg::*;

    localparam int SYNC_STAGES = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sclk_i = 1'b0;
    logic              copi_i = 1'b0;
    logic              ncs_i = 1'b1;
    logic              wr_valid_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [DATA_W-1:0] wr_data_o;
    logic              frame_err_o;
    logic [3:0]        err_cnt_o;
    logic              busy_o;

    spi_frame_rx #(.SYNC_STAGES(SYNC_STAGES), .FRAME_BITS(16), .MAX_ADDR(4)) dut (
        .clk(clk), .rst_n(rst_n), .sclk_i(sclk_i), .copi_i(copi_i), .ncs_i(ncs_i),
        .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .frame_err_o(frame_err_o), .err_cnt_o(err_cnt_o), .busy_o(busy_o)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected {addr,data} of every write strobe, in order.
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    int wr_pulses = 0;
    int err_pulses = 0;
    int last_wr_cyc = 0;

    always @(negedge clk) begin
        logic [ADDR_W+DATA_W-1:0] exp;
        if (wr_valid_o) begin
            wr_pulses++;
            last_wr_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe actual=%0h_%0h required=none", wr_addr_o, wr_data_o);
            end else begin
                exp = exp_q.pop_front();
                if ({wr_addr_o, wr_data_o} !== exp) begin
                    errors++;
                    $display("FAIL strobe_payload actual=%0h required=%0h", {wr_addr_o, wr_data_o}, exp);
                end
            end
        end
        if (frame_err_o) err_pulses++;
    end

    // Driver
    logic busy_mid;
    int   ncs_rise_cyc;

    task automatic send_frame(input logic [31:0] bits, input int nbits, input int half, input int gap);
        @(negedge clk);
        ncs_i = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi_i = bits[i];
            sclk_i = 1'b0;
            repeat (half) @(negedge clk);
            sclk_i = 1'b1;
            repeat (half) @(negedge clk);
        end
        sclk_i = 1'b0;
        repeat (half) @(negedge clk);
        busy_mid = busy_o;
        ncs_i = 1'b1;
        ncs_rise_cyc = cyc;
        repeat (gap) @(negedge clk);
    endtask

    typedef struct {
        logic [31:0]       bits;
        int                nbits;
        int                half;
        logic              exp_wr;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_data;
        logic              exp_err;
        logic [3:0]        exp_cnt;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr0, er0;
        logic [ADDR_W-1:0] held_addr;
        logic [DATA_W-1:0] held_data;

        vecs[0] = '{32'h8190,  16, 4, 1'b1, 7'h01, 8'h90, 1'b0, 4'd0};
        vecs[1] = '{32'h0255,  16, 4, 1'b0, 7'h00, 8'h00, 1'b0, 4'd0};
        vecs[2] = '{32'h85AA,  16, 4, 1'b0, 7'h00, 8'h00, 1'b1, 4'd1};
        vecs[3] = '{32'h4190,  15, 4, 1'b0, 7'h00, 8'h00, 1'b1, 4'd2};
        vecs[4] = '{32'h18190, 17, 4, 1'b0, 7'h00, 8'h00, 1'b1, 4'd3};
        vecs[5] = '{32'h80FF,  16, 4, 1'b1, 7'h00, 8'hFF, 1'b0, 4'd3};
        vecs[6] = '{32'h8433,  16, 3, 1'b1, 7'h04, 8'h33, 1'b0, 4'd3};
        vecs[7] = '{32'hFF00,  16, 3, 1'b0, 7'h00, 8'h00, 1'b1, 4'd4};
        vecs[8] = '{32'h0000,   0, 3, 1'b0, 7'h00, 8'h00, 1'b1, 4'd5};
        vecs[9] = '{32'h87A5,  16, 4, 1'b0, 7'h00, 8'h00, 1'b1, 4'd6};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {wr_valid_o, frame_err_o, busy_o, err_cnt_o, wr_addr_o, wr_data_o}, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        held_addr = '0;
        held_data = '0;
        for (int v = 0; v < 10; v++) begin
            wr0 = wr_pulses;
            er0 = err_pulses;
            if (vecs[v].exp_wr) begin
                exp_q.push_back({vecs[v].exp_addr, vecs[v].exp_data});
                held_addr = vecs[v].exp_addr;
                held_data = vecs[v].exp_data;
            end
            send_frame(vecs[v].bits, vecs[v].nbits, vecs[v].half, 8);
            check($sformatf("v%0d_busy_in_frame", v), busy_mid, 1);
            check($sformatf("v%0d_busy_after", v), busy_o, 0);
            check($sformatf("v%0d_wr_pulses", v), wr_pulses - wr0, vecs[v].exp_wr);
            check($sformatf("v%0d_err_pulses", v), err_pulses - er0, vecs[v].exp_err);
            check($sformatf("v%0d_err_cnt", v), err_cnt_o, vecs[v].exp_cnt);
            check($sformatf("v%0d_held_payload", v), {wr_addr_o, wr_data_o}, {held_addr, held_data});
            if (vecs[v].exp_wr)
                check($sformatf("v%0d_latency", v), last_wr_cyc - ncs_rise_cyc, SYNC_STAGES + 2);
        end

        // Back-to-back frames at clk/6 with short nCS high time
        wr0 = wr_pulses;
        er0 = err_pulses;
        exp_q.push_back({7'h03, 8'h11});
        exp_q.push_back({7'h01, 8'h22});
        send_frame(32'h8311, 16, 3, 1);
        send_frame(32'h8122, 16, 3, 8);
        check("b2b_wr_pulses", wr_pulses - wr0, 2);
        check("b2b_err_pulses", err_pulses - er0, 0);

        // Reset after 8 bits of a third frame
        wr0 = wr_pulses;
        er0 = err_pulses;
        @(negedge clk);
        ncs_i = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 7; i >= 0; i--) begin
            copi_i = (i == 7);
            sclk_i = 1'b0;
            repeat (3) @(negedge clk);
            sclk_i = 1'b1;
            repeat (3) @(negedge clk);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_outputs", {wr_valid_o, frame_err_o, busy_o, err_cnt_o, wr_addr_o, wr_data_o}, 0);
        ncs_i = 1'b1;
        sclk_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midreset_wr_pulses", wr_pulses - wr0, 0);
        check("midreset_err_pulses", err_pulses - er0, 0);
        check("midreset_after", {busy_o, err_cnt_o, wr_addr_o, wr_data_o}, 0);

        // Error counter saturation
        er0 = err_pulses;
        for (int n = 0; n < 17; n++) send_frame(32'h5, 3, 3, 4);
        repeat (8) @(negedge clk);
        check("sat_err_pulses", err_pulses - er0, 17);
        check("sat_err_cnt", err_cnt_o, 15);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("sat_reset_err_cnt", err_cnt_o, 0);

        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
